// File: rtl/ctrl_pipe_if.sv
// Signal bundle between the ID stage and the pipeline control block: decoded controls in,
// stage registers, hazard and forwarding selects out.
interface ctrl_pipe_if;
  logic       reg_write_i;
  logic [2:0] alu_op_i;
  logic       alu_src_i;
  logic       alu_data1_i;
  logic       mem_write_i;
  logic       mem_read_i;
  logic       men_to_reg_i;
  logic [1:0] branch_jump_i;
  logic [4:0] rs1_i;
  logic [4:0] rs2_i;
  logic [4:0] rd_i;
  logic       branch_taken_i;

  logic       stall_o;
  logic       flush_o;

  logic       ex_reg_write_o;
  logic [2:0] ex_alu_op_o;
  logic       ex_alu_src_o;
  logic       ex_alu_data1_o;
  logic       ex_mem_write_o;
  logic       ex_mem_read_o;
  logic       ex_men_to_reg_o;
  logic [1:0] ex_branch_jump_o;
  logic [4:0] ex_rs1_o;
  logic [4:0] ex_rs2_o;
  logic [4:0] ex_rd_o;

  logic       mem_reg_write_o;
  logic       mem_mem_write_o;
  logic       mem_mem_read_o;
  logic       mem_men_to_reg_o;
  logic [4:0] mem_rd_o;

  logic       wb_reg_write_o;
  logic       wb_men_to_reg_o;
  logic [4:0] wb_rd_o;

  logic [1:0] forward_a_o;
  logic [1:0] forward_b_o;

  modport master (
    output reg_write_i, alu_op_i, alu_src_i, alu_data1_i, mem_write_i, mem_read_i,
           men_to_reg_i, branch_jump_i, rs1_i, rs2_i, rd_i, branch_taken_i,
    input  stall_o, flush_o,
           ex_reg_write_o, ex_alu_op_o, ex_alu_src_o, ex_alu_data1_o, ex_mem_write_o,
           ex_mem_read_o, ex_men_to_reg_o, ex_branch_jump_o, ex_rs1_o, ex_rs2_o, ex_rd_o,
           mem_reg_write_o, mem_mem_write_o, mem_mem_read_o, mem_men_to_reg_o, mem_rd_o,
           wb_reg_write_o, wb_men_to_reg_o, wb_rd_o,
           forward_a_o, forward_b_o
  );

  modport slave (
    input  reg_write_i, alu_op_i, alu_src_i, alu_data1_i, mem_write_i, mem_read_i,
           men_to_reg_i, branch_jump_i, rs1_i, rs2_i, rd_i, branch_taken_i,
    output stall_o, flush_o,
           ex_reg_write_o, ex_alu_op_o, ex_alu_src_o, ex_alu_data1_o, ex_mem_write_o,
           ex_mem_read_o, ex_men_to_reg_o, ex_branch_jump_o, ex_rs1_o, ex_rs2_o, ex_rd_o,
           mem_reg_write_o, mem_mem_write_o, mem_mem_read_o, mem_men_to_reg_o, mem_rd_o,
           wb_reg_write_o, wb_men_to_reg_o, wb_rd_o,
           forward_a_o, forward_b_o
  );
endinterface

// File: rtl/ctrl_pipe.sv
// Pipeline control: ID/EX, EX/MEM, MEM/WB control registers, load-use stall,
// branch redirect flush and EX operand forwarding selects.
module ctrl_pipe (
  input  logic        clk_i,
  input  logic        rst_i,
  ctrl_pipe_if.slave  bus
);

  typedef struct packed {
    logic       reg_write;
    logic [2:0] alu_op;
    logic       alu_src;
    logic       alu_data1;
    logic       mem_write;
    logic       mem_read;
    logic       men_to_reg;
    logic [1:0] branch_jump;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } ex_stage_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       mem_read;
    logic       men_to_reg;
    logic [4:0] rd;
  } mem_stage_t;

  typedef struct packed {
    logic       reg_write;
    logic       men_to_reg;
    logic [4:0] rd;
  } wb_stage_t;

  ex_stage_t  id_bundle;
  ex_stage_t  ex_q;
  mem_stage_t mem_q;
  wb_stage_t  wb_q;

  logic load_use;
  logic redirect;

  // MEM result is newer than WB, so it wins when both match.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input mem_stage_t m,
                                         input wb_stage_t w);
    logic [1:0] sel;
    sel = 2'b00;
    if (m.reg_write && (m.rd != 5'd0) && (m.rd == src))
      sel = 2'b10;
    else if (w.reg_write && (w.rd != 5'd0) && (w.rd == src))
      sel = 2'b01;
    return sel;
  endfunction

  always_comb begin
    id_bundle             = '0;
    id_bundle.reg_write   = bus.reg_write_i;
    id_bundle.alu_op      = bus.alu_op_i;
    id_bundle.alu_src     = bus.alu_src_i;
    id_bundle.alu_data1   = bus.alu_data1_i;
    id_bundle.mem_write   = bus.mem_write_i;
    id_bundle.mem_read    = bus.mem_read_i;
    id_bundle.men_to_reg  = bus.men_to_reg_i;
    id_bundle.branch_jump = bus.branch_jump_i;
    id_bundle.rs1         = bus.rs1_i;
    id_bundle.rs2         = bus.rs2_i;
    id_bundle.rd          = bus.rd_i;
  end

  always_comb begin
    load_use = ex_q.mem_read && (ex_q.rd != 5'd0) &&
               ((ex_q.rd == bus.rs1_i) || (ex_q.rd == bus.rs2_i));
    redirect = bus.branch_taken_i && (ex_q.branch_jump != 2'b00);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q             <= (redirect || load_use) ? '0 : id_bundle;
      mem_q.reg_write  <= ex_q.reg_write;
      mem_q.mem_write  <= ex_q.mem_write;
      mem_q.mem_read   <= ex_q.mem_read;
      mem_q.men_to_reg <= ex_q.men_to_reg;
      mem_q.rd         <= ex_q.rd;
      wb_q.reg_write   <= mem_q.reg_write;
      wb_q.men_to_reg  <= mem_q.men_to_reg;
      wb_q.rd          <= mem_q.rd;
    end
  end

  // A taken redirect squashes the ID instruction, so its hazard must not stall.
  assign bus.flush_o = redirect;
  assign bus.stall_o = load_use && !redirect;

  assign bus.forward_a_o = fwd_sel(ex_q.rs1, mem_q, wb_q);
  assign bus.forward_b_o = fwd_sel(ex_q.rs2, mem_q, wb_q);

  assign bus.ex_reg_write_o   = ex_q.reg_write;
  assign bus.ex_alu_op_o      = ex_q.alu_op;
  assign bus.ex_alu_src_o     = ex_q.alu_src;
  assign bus.ex_alu_data1_o   = ex_q.alu_data1;
  assign bus.ex_mem_write_o   = ex_q.mem_write;
  assign bus.ex_mem_read_o    = ex_q.mem_read;
  assign bus.ex_men_to_reg_o  = ex_q.men_to_reg;
  assign bus.ex_branch_jump_o = ex_q.branch_jump;
  assign bus.ex_rs1_o         = ex_q.rs1;
  assign bus.ex_rs2_o         = ex_q.rs2;
  assign bus.ex_rd_o          = ex_q.rd;

  assign bus.mem_reg_write_o  = mem_q.reg_write;
  assign bus.mem_mem_write_o  = mem_q.mem_write;
  assign bus.mem_mem_read_o   = mem_q.mem_read;
  assign bus.mem_men_to_reg_o = mem_q.men_to_reg;
  assign bus.mem_rd_o         = mem_q.rd;

  assign bus.wb_reg_write_o   = wb_q.reg_write;
  assign bus.wb_men_to_reg_o  = wb_q.men_to_reg;
  assign bus.wb_rd_o          = wb_q.rd;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Bench for ctrl_pipe: directed hazard scenarios plus random instruction streams,
// checked against a queue-of-instructions pipeline model.
module tb_ctrl_pipe;

  typedef struct packed {
    logic       reg_write;
    logic [2:0] alu_op;
    logic       alu_src;
    logic       alu_data1;
    logic       mem_write;
    logic       mem_read;
    logic       men_to_reg;
    logic [1:0] branch_jump;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } instr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ctrl_pipe_if bus ();

  ctrl_pipe u_dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Instruction currently in EX, MEM, WB (index 1..3); full bundles, subsets compared.
  instr_t stage [1:3];

  logic        obs_stall, obs_flush;
  logic [1:0]  obs_fa, obs_fb;
  logic [31:0] obs_ex, obs_mem, obs_wb;
  logic        exp_stall;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] pack_ex(input instr_t b);
    return {6'd0, b};
  endfunction

  function automatic logic [31:0] pack_mem(input instr_t b);
    return {23'd0, b.reg_write, b.mem_write, b.mem_read, b.men_to_reg, b.rd};
  endfunction

  function automatic logic [31:0] pack_wb(input instr_t b);
    return {25'd0, b.reg_write, b.men_to_reg, b.rd};
  endfunction

  function automatic logic model_load_use(input instr_t id);
    return stage[1].mem_read && stage[1].rd != 0 &&
           (stage[1].rd == id.rs1 || stage[1].rd == id.rs2);
  endfunction

  function automatic logic model_redirect(input logic bt);
    return bt && stage[1].branch_jump != 0;
  endfunction

  // Youngest older producer wins: scan MEM (stage 2) then WB (stage 3).
  function automatic logic [1:0] model_fwd(input logic [4:0] src);
    for (int s = 2; s <= 3; s++)
      if (src != 0 && stage[s].reg_write && stage[s].rd == src)
        return (s == 2) ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction

  task automatic drive(input instr_t b, input logic bt);
    bus.reg_write_i    = b.reg_write;
    bus.alu_op_i       = b.alu_op;
    bus.alu_src_i      = b.alu_src;
    bus.alu_data1_i    = b.alu_data1;
    bus.mem_write_i    = b.mem_write;
    bus.mem_read_i     = b.mem_read;
    bus.men_to_reg_i   = b.men_to_reg;
    bus.branch_jump_i  = b.branch_jump;
    bus.rs1_i          = b.rs1;
    bus.rs2_i          = b.rs2;
    bus.rd_i           = b.rd;
    bus.branch_taken_i = bt;
  endtask

  task automatic cycle(input instr_t id, input logic bt, input logic r);
    logic lu, rd;
    drive(id, bt);
    rst = r;
    @(negedge clk);
    lu = model_load_use(id);
    rd = model_redirect(bt);
    exp_stall = lu && !rd;
    obs_stall = bus.stall_o;
    obs_flush = bus.flush_o;
    obs_fa    = bus.forward_a_o;
    obs_fb    = bus.forward_b_o;
    obs_ex    = {6'd0, bus.ex_reg_write_o, bus.ex_alu_op_o, bus.ex_alu_src_o,
                 bus.ex_alu_data1_o, bus.ex_mem_write_o, bus.ex_mem_read_o,
                 bus.ex_men_to_reg_o, bus.ex_branch_jump_o, bus.ex_rs1_o,
                 bus.ex_rs2_o, bus.ex_rd_o};
    obs_mem   = {23'd0, bus.mem_reg_write_o, bus.mem_mem_write_o, bus.mem_mem_read_o,
                 bus.mem_men_to_reg_o, bus.mem_rd_o};
    obs_wb    = {25'd0, bus.wb_reg_write_o, bus.wb_men_to_reg_o, bus.wb_rd_o};
    check("stall", {31'd0, obs_stall}, {31'd0, exp_stall});
    check("flush", {31'd0, obs_flush}, {31'd0, rd});
    check("fwd_a", {30'd0, obs_fa}, {30'd0, model_fwd(stage[1].rs1)});
    check("fwd_b", {30'd0, obs_fb}, {30'd0, model_fwd(stage[1].rs2)});
    check("ex",  obs_ex,  pack_ex(stage[1]));
    check("mem", obs_mem, pack_mem(stage[2]));
    check("wb",  obs_wb,  pack_wb(stage[3]));
    @(posedge clk);
    if (r) begin
      for (int s = 1; s <= 3; s++) stage[s] = '0;
    end else begin
      stage[3] = stage[2];
      stage[2] = stage[1];
      stage[1] = (lu || rd) ? instr_t'('0) : id;
    end
    #1;
  endtask

  function automatic instr_t rand_instr();
    instr_t b;
    b     = instr_t'($urandom);
    b.rs1 = 5'($urandom_range(0, 3));
    b.rs2 = 5'($urandom_range(0, 3));
    b.rd  = 5'($urandom_range(0, 3));
    return b;
  endfunction

  instr_t nop, ld, add, sub, br, x;

  initial begin
    for (int s = 1; s <= 3; s++) stage[s] = '0;
    nop = '0;
    drive(nop, 1'b0);
    #1;
    cycle(nop, 1'b0, 1'b1);
    cycle(nop, 1'b0, 1'b1);
    check("rst_quiet", {28'd0, obs_stall, obs_flush, obs_fa != 0, obs_fb != 0}, 32'd0);

    // Load x5 then dependent add: one bubble, then WB forward.
    ld = '0; ld.reg_write = 1; ld.mem_read = 1; ld.men_to_reg = 1; ld.rd = 5'd5; ld.rs1 = 5'd1;
    add = '0; add.reg_write = 1; add.rs1 = 5'd5; add.rs2 = 5'd2; add.rd = 5'd6;
    cycle(ld, 1'b0, 1'b0);
    cycle(add, 1'b0, 1'b0);
    check("lu_stall", {31'd0, obs_stall}, 32'd1);
    cycle(add, 1'b0, 1'b0);
    check("lu_bubble", obs_ex, 32'd0);
    check("lu_unstall", {31'd0, obs_stall}, 32'd0);
    cycle(nop, 1'b0, 1'b0);
    check("lu_fwd_a", {30'd0, obs_fa}, 32'd1);

    // Back-to-back producer/consumer: MEM forward; with a gap: WB forward.
    add = '0; add.reg_write = 1; add.rd = 5'd3; add.rs1 = 5'd1;
    sub = '0; sub.reg_write = 1; sub.rs1 = 5'd2; sub.rs2 = 5'd3; sub.rd = 5'd4;
    cycle(add, 1'b0, 1'b0);
    cycle(sub, 1'b0, 1'b0);
    check("b2b_nostall", {31'd0, obs_stall}, 32'd0);
    cycle(nop, 1'b0, 1'b0);
    check("b2b_fwd_b", {30'd0, obs_fb}, 32'd2);
    cycle(add, 1'b0, 1'b0);
    cycle(nop, 1'b0, 1'b0);
    cycle(sub, 1'b0, 1'b0);
    cycle(nop, 1'b0, 1'b0);
    check("gap_fwd_b", {30'd0, obs_fb}, 32'd1);

    // Taken branch in EX beats a load-use hazard in ID.
    br = '0; br.branch_jump = 2'b01; br.mem_read = 1; br.rd = 5'd7;
    x  = '0; x.reg_write = 1; x.rs1 = 5'd7; x.rd = 5'd9;
    cycle(br, 1'b0, 1'b0);
    cycle(x, 1'b1, 1'b0);
    check("br_flush", {31'd0, obs_flush}, 32'd1);
    check("br_nostall", {31'd0, obs_stall}, 32'd0);
    cycle(nop, 1'b0, 1'b0);
    check("br_bubble", obs_ex, 32'd0);

    // branch_taken without a branch code in EX is ignored.
    br = '0; br.reg_write = 1; br.rd = 5'd8;
    x  = '0; x.alu_op = 3'd5; x.rs1 = 5'd10; x.rd = 5'd11;
    cycle(br, 1'b0, 1'b0);
    cycle(x, 1'b1, 1'b0);
    check("nobr_flush", {31'd0, obs_flush}, 32'd0);
    cycle(nop, 1'b0, 1'b0);
    check("nobr_adv", obs_ex, {6'd0, x});

    // x0 never stalls nor forwards.
    ld = '0; ld.reg_write = 1; ld.mem_read = 1; ld.rd = 5'd0;
    x  = '0; x.reg_write = 1; x.rs1 = 5'd0; x.rd = 5'd2;
    cycle(ld, 1'b0, 1'b0);
    cycle(x, 1'b0, 1'b0);
    check("x0_nostall", {31'd0, obs_stall}, 32'd0);
    cycle(nop, 1'b0, 1'b0);
    check("x0_nofwd", {30'd0, obs_fa}, 32'd0);

    // Reset during a stall with all stages occupied.
    ld = '0; ld.reg_write = 1; ld.mem_read = 1; ld.rd = 5'd5;
    add = '0; add.reg_write = 1; add.rs1 = 5'd5; add.rd = 5'd6;
    x = '0; x.reg_write = 1; x.rd = 5'd12; x.mem_write = 1;
    cycle(x, 1'b0, 1'b0);
    cycle(x, 1'b0, 1'b0);
    cycle(ld, 1'b0, 1'b0);
    cycle(add, 1'b0, 1'b0);
    check("rst_mid_stall", {31'd0, obs_stall}, 32'd1);
    cycle(add, 1'b0, 1'b1);
    cycle(nop, 1'b0, 1'b0);
    check("rst_all_ex",  obs_ex,  32'd0);
    check("rst_all_mem", obs_mem, 32'd0);
    check("rst_all_wb",  obs_wb,  32'd0);
    check("rst_all_ctl", {28'd0, obs_stall, obs_flush, obs_fa != 0, obs_fb != 0}, 32'd0);

    // Random streams; a stalled instruction is re-presented until it issues.
    x = rand_instr();
    for (int n = 0; n < 3000; n++) begin
      logic bt, r;
      bt = ($urandom_range(0, 3) == 0);
      r  = ($urandom_range(0, 99) == 0);
      cycle(x, bt, r);
      if (!exp_stall || r) x = rand_instr();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
